// File: rtl/step_clock_gen.sv
// Tempo-driven step clock: a phase accumulator turns BPM and steps-per-beat into
// single-cycle Step/Beat pulses with a wrapping step index.
module step_clock_gen #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BPM_W     = 9,
  parameter int unsigned NUM_STEPS = 16,
  localparam int unsigned IDX_W    = $clog2(NUM_STEPS)
) (
  input  logic             Clock,
  input  logic             nStart,
  input  logic             Run,
  input  logic [BPM_W-1:0] BPM,
  input  logic [1:0]       Div,
  input  logic             Restart,
  output logic             Step,
  output logic [IDX_W-1:0] StepIndex,
  output logic             Beat,
  output logic             Running
);

  // One minute of clock cycles is one full phase turn per quarter note at 1 BPM.
  localparam longint unsigned LIMIT = 64'(CLK_HZ) * 64'd60;
  localparam int unsigned     ACC_W = $clog2(LIMIT) + 1;
  localparam int unsigned     INC_W = BPM_W + 3;

  localparam logic [ACC_W-1:0] LIMIT_A  = ACC_W'(LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [INC_W-1:0]   inc;
  logic [ACC_W-1:0]   sum;
  logic [IDX_W-1:0]   next_idx;
  logic [IDX_W-1:0]   div_mask;
  logic               beat_hit;

  assign inc      = INC_W'(BPM) << Div;
  assign sum      = acc + ACC_W'(inc);
  assign next_idx = (StepIndex == LAST_IDX) ? '0 : StepIndex + IDX_W'(1);
  assign div_mask = IDX_W'((9'd1 << Div) - 9'd1);
  assign beat_hit = ((next_idx & div_mask) == '0);
  assign Running  = (state == RUN);

  // NOTE: every register here, accumulator included, is cleared by the async reset
  // and updated with non-blocking assignments so all state moves on the same edge.
  always_ff @(posedge Clock or negedge nStart) begin
    if (!nStart) begin
      state     <= IDLE;
      acc       <= '0;
      StepIndex <= '0;
      Step      <= 1'b0;
      Beat      <= 1'b0;
    end else begin
      Step <= 1'b0;
      Beat <= 1'b0;
      case (state)
        IDLE: begin
          if (Run) begin
            state     <= RUN;
            acc       <= '0;
            StepIndex <= '0;
            Step      <= 1'b1;
            Beat      <= 1'b1;
          end
        end
        RUN: begin
          if (!Run) begin
            state     <= IDLE;
            acc       <= '0;
            StepIndex <= '0;
          end else if (Restart) begin
            acc       <= '0;
            StepIndex <= '0;
            Step      <= 1'b1;
            Beat      <= 1'b1;
          end else if (BPM != '0) begin
            // Carrying the remainder keeps the long-run period exact.
            if (sum >= LIMIT_A) begin
              acc       <= sum - LIMIT_A;
              StepIndex <= next_idx;
              Step      <= 1'b1;
              Beat      <= beat_hit;
            end else begin
              acc <= sum;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// Scoreboard bench for step_clock_gen: expected step events are queued as stimulus
// is applied and matched against Step/StepIndex/Beat on the falling clock edge.
module tb_step_clock_gen;

  logic       Clock;
  logic       nStart;
  logic       Run;
  logic [8:0] BPM;
  logic [1:0] Div;
  logic       Restart;
  logic       Step;
  logic [3:0] StepIndex;
  logic       Beat;
  logic       Running;

  step_clock_gen #(.CLK_HZ(100), .BPM_W(9), .NUM_STEPS(16)) dut (
    .Clock(Clock), .nStart(nStart), .Run(Run), .BPM(BPM), .Div(Div),
    .Restart(Restart), .Step(Step), .StepIndex(StepIndex), .Beat(Beat),
    .Running(Running)
  );

  typedef struct {
    int cyc;
    int idx;
    bit beat;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  cyc = 0;
  int  n_assert = 0;
  int  n_fail = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int idx, input bit beat);
    ev_t e;
    e.cyc  = c;
    e.idx  = idx;
    e.beat = beat;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge Clock);
  endtask

  // Scoreboard consumer: every Step must match the head of the queue in cycle,
  // index and beat; expected events whose cycle has passed count as missed.
  always @(negedge Clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missed_step_cycle", cyc, exp_q[0].cyc);
      mon_ev = exp_q.pop_front();
    end
    if (Step) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", Step, 1'b0);
      end else if (exp_q[0].cyc != cyc) begin
        check("step_cycle", cyc, exp_q[0].cyc);
      end else begin
        mon_ev = exp_q.pop_front();
        check("step_index", StepIndex, mon_ev.idx);
        check("step_beat", Beat, mon_ev.beat);
      end
    end else if (Beat) begin
      check("beat_without_step", Beat, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d reached time limit, expected under 2000", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int t0, e1, e2, e3, r;
    nStart  = 1'b0;
    Run     = 1'b0;
    BPM     = 9'd120;
    Div     = 2'd0;
    Restart = 1'b0;

    // Reset state
    wait_until(2);
    check("reset_step", Step, 1'b0);
    check("reset_beat", Beat, 1'b0);
    check("reset_index", StepIndex, 4'd0);
    check("reset_running", Running, 1'b0);
    wait_until(3);
    nStart = 1'b1;
    wait_until(6);
    check("idle_running", Running, 1'b0);

    // 120 BPM, one step per beat: downbeat at once, then every 50 cycles
    t0 = cyc;
    Run = 1'b1;
    push(t0 + 1, 0, 1'b1);
    for (int n = 1; n <= 17; n++) push(t0 + 1 + 50 * n, n % 16, 1'b1);
    wait_until(t0 + 1);
    check("run_running", Running, 1'b1);
    e1 = t0 + 1 + 850;
    wait_until(e1);

    // Four steps per beat: INC=480, step n lands at ceil(12.5*n)
    Div = 2'd2;
    for (int n = 1; n <= 16; n++) begin
      int idx;
      idx = (1 + n) % 16;
      push(e1 + (25 * n + 1) / 2, idx, (idx % 4) == 0);
    end
    e2 = e1 + 200;
    wait_until(e2);

    // Pause 100 cycles with 2400 of 6000 phase banked; 30 more cycles needed after
    Div = 2'd0;
    push(e2 + 150, 2, 1'b1);
    push(e2 + 200, 3, 1'b1);
    wait_until(e2 + 20);
    BPM = 9'd0;
    wait_until(e2 + 70);
    check("pause_index", StepIndex, 4'd1);
    check("pause_running", Running, 1'b1);
    wait_until(e2 + 120);
    BPM = 9'd120;
    e3 = e2 + 200;
    wait_until(e3);

    // Restart at index 7 re-arms the downbeat
    for (int n = 1; n <= 4; n++) push(e3 + 50 * n, 3 + n, 1'b1);
    wait_until(e3 + 210);
    check("pre_restart_index", StepIndex, 4'd7);
    Restart = 1'b1;
    push(e3 + 211, 0, 1'b1);
    push(e3 + 261, 1, 1'b1);
    wait_until(e3 + 211);
    Restart = 1'b0;
    r = e3 + 261;
    wait_until(r);

    // Stop at index 5, then run again
    for (int n = 1; n <= 4; n++) push(r + 50 * n, 1 + n, 1'b1);
    wait_until(r + 220);
    check("pre_stop_index", StepIndex, 4'd5);
    Run = 1'b0;
    wait_until(r + 221);
    check("stop_running", Running, 1'b0);
    check("stop_index", StepIndex, 4'd0);
    wait_until(r + 225);
    Run = 1'b1;
    push(r + 226, 0, 1'b1);
    push(r + 276, 1, 1'b1);
    wait_until(r + 226);
    check("rerun_running", Running, 1'b1);
    wait_until(r + 276);

    // Asynchronous reset while Step is high, then release with Run held high
    #2 nStart = 1'b0;
    #1;
    check("async_step", Step, 1'b0);
    check("async_beat", Beat, 1'b0);
    check("async_index", StepIndex, 4'd0);
    check("async_running", Running, 1'b0);
    wait_until(r + 279);
    nStart = 1'b1;
    push(r + 280, 0, 1'b1);
    push(r + 330, 1, 1'b1);
    wait_until(r + 330);

    // Restart ignored in IDLE; Run and Restart together give one downbeat
    wait_until(r + 335);
    Run = 1'b0;
    wait_until(r + 340);
    Restart = 1'b1;
    wait_until(r + 342);
    check("idle_restart_running", Running, 1'b0);
    Restart = 1'b0;
    wait_until(r + 345);
    Run = 1'b1;
    Restart = 1'b1;
    push(r + 346, 0, 1'b1);
    push(r + 396, 1, 1'b1);
    wait_until(r + 346);
    Restart = 1'b0;
    wait_until(r + 400);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
